dtc_pe_feeder: RTL and testbench
================================

Name: dtc_pe_feeder

Overview:
- Streaming operand front-end and result collector for the dot-product PE (N_MUL lanes, fixed pipeline latency, no valid/ready of its own).
- Accepts one (a,b) element pair per cycle via valid/ready, packs N_MUL pairs into the PE's packed in_a/in_b buses and issues them with a strobe.
- Tracks each issue through a PE_LAT-deep tag line, then accumulates the PE's per-chunk results into a full dot product.
- A dot product longer than N_MUL is split into chunks; s_last ends it.

Parameters:
- N_MUL, 8, lanes per PE vector.
- DW_MUL, 32, element width.
- DW_ADD, 32, PE result width (signed).
- DW_ACC, 32, accumulator/output width (signed, wraps modulo 2^DW_ACC).
- PE_LAT, 4, cycles from PE input registered to pe_out valid (1 multiplier stage + log2(N_MUL) adder stages).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous clear of all in-flight state.
- s_valid  in  1  element pair valid.
- s_ready  out  1  element pair accepted when s_valid&s_ready.
- s_a  in  DW_MUL  operand a element.
- s_b  in  DW_MUL  operand b element.
- s_last  in  1  final element of this dot product.
- pe_a  out  DW_MUL*N_MUL  packed operand a to PE.
- pe_b  out  DW_MUL*N_MUL  packed operand b to PE.
- pe_vld  out  1  one-cycle issue strobe.
- pe_out  in  DW_ADD  PE result.
- out_vld  out  1  one-cycle result strobe.
- out_data  out  DW_ACC  completed dot product.

Behaviour:
- Reset (rst_n=0, async): all outputs, lane index, pack buffers, tag line and accumulator are 0.
- s_ready = !flush. There is no backpressure otherwise: full rate, 1 element/cycle sustained.
- Packing:
  - The element accepted at lane index idx goes to bits [DW_MUL*idx +: DW_MUL] of the pack buffers.
  - idx increments per accept.
- FSM states:
  - EMPTY (idx==0) -> PARTIAL on an accept without completion.
  - PARTIAL -> EMPTY on completion or flush.
- Completion is an accept with idx==N_MUL-1 or s_last=1. On the next edge:
  - pe_a/pe_b load the pack buffer with the current element merged in; never-written lanes are 0.
  - pe_vld=1.
  - Tag line head loads {vld=1, last=s_last}.
  - idx and the pack buffers clear.
- A new element accepted in the completion+1 cycle lands in lane 0 (no bubble).
- pe_a/pe_b hold their value while pe_vld=0.
- Tag line: PE_LAT-deep shift register of {vld,last}, aligned so the tap is valid in the same cycle the PE presents that vector's pe_out.
- At a valid tap, sum = acc + sign-extend(pe_out):
  - last=0: acc <= sum.
  - last=1: out_data <= sum, out_vld <= 1 next edge, acc <= 0.
- Latency: last element accepted in cycle t -> pe_vld in t+1 -> out_vld in t+2+PE_LAT.
- out_data holds until the next out_vld.
- A chunk of N_MUL elements without s_last continues the same dot product; s_last on an element with idx==N_MUL-1 completes both chunk and product.
- s_last on the first element gives a 1-lane vector.
- flush (synchronous) clears idx, pack buffers, tag line, acc and out_vld; the element presented in that cycle is not accepted. pe_a/pe_b/out_data keep their values.
- Reset mid-operation discards everything; no out_vld follows.

Optional Feature:
- Macro: DTC_FEEDER_PERF_EN.
- Defined: adds outputs perf_issue_cnt and perf_result_cnt (32 bits each), incremented on pe_vld and out_vld respectively.
  - Both counters clear on reset only (not flush) and wrap at 2^32.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package dtc_pkg holds:
  - Default lane/width constants (N_MUL, DW_MUL, DW_ADD).
  - PE_LAT derivation (1 + clog2(N_MUL)).
  - The FSM state encoding.
- One natural sub-module, dtc_tag_pipe: a parameterised depth×width shift register with sync flush and async active-low reset, used for the tag line.

Test Plan:
- Bench drives the PE port with a behavioural PE_LAT-cycle dot-product model.
- Full vector: 8 pairs a=1..8, b=1, last on 8th (accepted t..t+7) -> pe_vld at t+8, one out_vld at t+13, out_data=36.
- Partial vector: 3 pairs a=2,3,4, b=5, last on 3rd -> lanes 3..7 of pe_a/pe_b zero, out_data=45.
- Multi-chunk: 12 pairs a=1, b=k (k=1..12), last on 12th -> two pe_vld strobes, single out_vld with out_data=78.
- Back-to-back: three 8-element products with continuous s_valid -> s_ready stays 1, out_vld strobes exactly 8 cycles apart, sums correct; negative operands (a=-3, b=7, 8 lanes) -> -168.
- Flush mid-fill: 5 pairs, flush, then 8-pair product of ones -> out_data=8, no stale lanes; flush with s_valid high -> element not counted.
- Reset mid-operation: assert rst_n=0 with 2 vectors in the tag line -> all outputs 0 immediately, no out_vld after release; with DTC_FEEDER_PERF_EN counters read 0, then increment 1 per issue/result.

Source files
------------

// File: rtl/dtc_pkg.sv
// dtc_pkg: shared lane/width constants, PE latency and fill-state encoding
// for the dot-product PE feeder.
package dtc_pkg;

  localparam int DTC_N_MUL  = 8;
  localparam int DTC_DW_MUL = 32;
  localparam int DTC_DW_ADD = 32;
  localparam int DTC_DW_ACC = 32;

  function automatic int pe_lat(input int n);
    return 1 + $clog2(n);
  endfunction

  localparam int DTC_PE_LAT = pe_lat(DTC_N_MUL);

  typedef enum logic {
    FILL_EMPTY   = 1'b0,
    FILL_PARTIAL = 1'b1
  } fill_e;

endpackage

// File: rtl/dtc_pe_feeder_if.sv
// dtc_pe_feeder_if: element-pair stream (valid/ready) into the PE feeder.
// master drives elements, slave (the feeder) returns ready.
interface dtc_pe_feeder_if #(
  parameter int DW = 32
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_a;
  logic [DW-1:0] s_b;
  logic          s_last;

  modport master (
    output s_valid, s_a, s_b, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_a, s_b, s_last,
    output s_ready
  );
endinterface

// File: rtl/dtc_tag_pipe.sv
// dtc_tag_pipe: DEPTH x WIDTH shift register, sync flush, async reset.
// Tracks issued vectors until their PE result appears.
module dtc_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        sr_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++)
        sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++)
        sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dtc_pe_feeder.sv
// dtc_pe_feeder: packs element pairs into PE vectors, collects chunk results
// into dot products. Optional perf counters under DTC_FEEDER_PERF_EN.
module dtc_pe_feeder
  import dtc_pkg::*;
#(
  parameter int N_MUL  = DTC_N_MUL,
  parameter int DW_MUL = DTC_DW_MUL,
  parameter int DW_ADD = DTC_DW_ADD,
  parameter int DW_ACC = DTC_DW_ACC,
  parameter int PE_LAT = pe_lat(N_MUL)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  dtc_pe_feeder_if.slave          s,
  output logic [DW_MUL*N_MUL-1:0] pe_a,
  output logic [DW_MUL*N_MUL-1:0] pe_b,
  output logic                    pe_vld,
  input  logic [DW_ADD-1:0]       pe_out,
  output logic                    out_vld,
  output logic [DW_ACC-1:0]       out_data
`ifdef DTC_FEEDER_PERF_EN
  ,
  output logic [31:0]             perf_issue_cnt,
  output logic [31:0]             perf_result_cnt
`endif
);

  localparam int IW = (N_MUL > 1) ? $clog2(N_MUL) : 1;
  localparam int PW = DW_MUL * N_MUL;

  fill_e          state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [PW-1:0]  pk_a_q, pk_a_d;
  logic [PW-1:0]  pk_b_q, pk_b_d;
  logic [PW-1:0]  pe_a_q, pe_a_d;
  logic [PW-1:0]  pe_b_q, pe_b_d;
  logic [PW-1:0]  mrg_a, mrg_b;
  logic           vld_q, vld_d;
  logic           last_q, last_d;
  logic [DW_ACC-1:0] acc_q, acc_d;
  logic [DW_ACC-1:0] od_q, od_d;
  logic [DW_ACC-1:0] sum;
  logic           ov_q, ov_d;
  logic           take, lane_end, done;
  logic [1:0]     tap;

  assign s.s_ready = ~flush;
  assign take      = s.s_valid & ~flush;
  assign lane_end  = (idx_q == IW'(N_MUL-1));
  assign done      = take & (lane_end | s.s_last);

  always_comb begin
    mrg_a = pk_a_q;
    mrg_b = pk_b_q;
    mrg_a[DW_MUL*int'(idx_q) +: DW_MUL] = s.s_a;
    mrg_b[DW_MUL*int'(idx_q) +: DW_MUL] = s.s_b;
    idx_d  = idx_q;
    pk_a_d = pk_a_q;
    pk_b_d = pk_b_q;
    pe_a_d = pe_a_q;
    pe_b_d = pe_b_q;
    vld_d  = done;
    last_d = done & s.s_last;
    if (flush) begin
      idx_d  = '0;
      pk_a_d = '0;
      pk_b_d = '0;
    end else if (done) begin
      idx_d  = '0;
      pk_a_d = '0;
      pk_b_d = '0;
      pe_a_d = mrg_a;
      pe_b_d = mrg_b;
    end else if (take) begin
      idx_d  = idx_q + IW'(1);
      pk_a_d = mrg_a;
      pk_b_d = mrg_b;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL_EMPTY:   if (take && !done) state_d = FILL_PARTIAL;
      FILL_PARTIAL: if (flush || done) state_d = FILL_EMPTY;
    endcase
  end

  // head regs sit alongside pe_vld; the pipe covers the PE's own latency
  dtc_tag_pipe #(
    .DEPTH (PE_LAT),
    .WIDTH (2)
  ) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .d_i     ({vld_q, last_q}),
    .q_o     (tap)
  );

  assign sum = acc_q + DW_ACC'(signed'(pe_out));

  always_comb begin
    acc_d = acc_q;
    od_d  = od_q;
    ov_d  = 1'b0;
    unique case (1'b1)
      flush: acc_d = '0;
      (!flush && tap[1] && tap[0]): begin
        od_d  = sum;
        ov_d  = 1'b1;
        acc_d = '0;
      end
      (!flush && tap[1] && !tap[0]): acc_d = sum;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL_EMPTY;
      idx_q   <= '0;
      pk_a_q  <= '0;
      pk_b_q  <= '0;
      pe_a_q  <= '0;
      pe_b_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pk_a_q  <= pk_a_d;
      pk_b_q  <= pk_b_d;
      pe_a_q  <= pe_a_d;
      pe_b_q  <= pe_b_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
    end
  end

  assign pe_a     = pe_a_q;
  assign pe_b     = pe_b_q;
  assign pe_vld   = vld_q;
  assign out_vld  = ov_q;
  assign out_data = od_q;

`ifdef DTC_FEEDER_PERF_EN
  logic [31:0] iss_q, res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q <= '0;
      res_q <= '0;
    end else begin
      iss_q <= iss_q + {31'd0, vld_q};
      res_q <= res_q + {31'd0, ov_q};
    end
  end

  assign perf_issue_cnt  = iss_q;
  assign perf_result_cnt = res_q;
`endif

endmodule

// File: tb/tb_dtc_pe_feeder.sv
// tb_dtc_pe_feeder: directed vectors against dtc_pe_feeder with a
// behavioural PE_LAT-cycle dot-product PE on the pe_* port.
module tb_dtc_pe_feeder;
  import dtc_pkg::*;

  localparam int N  = DTC_N_MUL;
  localparam int W  = DTC_DW_MUL;
  localparam int PW = N * W;
  localparam int L  = DTC_PE_LAT;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [PW-1:0] pe_a, pe_b;
  logic          pe_vld;
  logic [31:0]   pe_out;
  logic          out_vld;
  logic [31:0]   out_data;
`ifdef DTC_FEEDER_PERF_EN
  logic [31:0]   perf_issue_cnt, perf_result_cnt;
`endif

  dtc_pe_feeder_if #(.DW(W)) s_if ();

  always #5 clk = ~clk;

  dtc_pe_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .s        (s_if),
    .pe_a     (pe_a),
    .pe_b     (pe_b),
    .pe_vld   (pe_vld),
    .pe_out   (pe_out),
    .out_vld  (out_vld),
`ifdef DTC_FEEDER_PERF_EN
    .perf_issue_cnt  (perf_issue_cnt),
    .perf_result_cnt (perf_result_cnt),
`endif
    .out_data (out_data)
  );

  function automatic logic [31:0] dot(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++)
      acc = acc + a[i*W +: W] * b[i*W +: W];
    return acc;
  endfunction

  // PE: inputs captured at the edge after pe_vld, result L cycles on
  logic [31:0] pr [L];
  always @(posedge clk) begin
    pr[0] <= dot(pe_a, pe_b);
    for (int i = 1; i < L; i++)
      pr[i] <= pr[i-1];
  end
  assign pe_out = pr[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            pv_c[$];
  logic [PW-1:0] pv_a[$];
  logic [PW-1:0] pv_b[$];
  int            ov_c[$];
  logic [31:0]   ov_d[$];

  always @(negedge clk) begin
    if (pe_vld) begin
      pv_c.push_back(cyc);
      pv_a.push_back(pe_a);
      pv_b.push_back(pe_b);
    end
    if (out_vld) begin
      ov_c.push_back(cyc);
      ov_d.push_back(out_data);
    end
  end

  int nvec = 0;
  int nerr = 0;
  int last_c = 0;
  int rdy_lo = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input int b, input bit last);
    s_if.s_valid = 1'b1;
    s_if.s_a     = a;
    s_if.s_b     = b;
    s_if.s_last  = last;
    if (!s_if.s_ready) rdy_lo++;
    last_c = cyc;
    tick();
  endtask

  task automatic idle(input int n);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clr();
    pv_c.delete(); pv_a.delete(); pv_b.delete();
    ov_c.delete(); ov_d.delete();
  endtask

  function automatic logic [PW-1:0] lanes(input int v0, input int step, input int n);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[i*W +: W] = W'(v0 + step * i);
    return r;
  endfunction

  int oc0, oc1, oc2;

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_a     = '0;
    s_if.s_b     = '0;
    s_if.s_last  = 1'b0;
    repeat (2) tick();
    chk("rst_pe_vld", pe_vld, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pe_a", pe_a, 0);
    chk("rst_pe_b", pe_b, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", s_if.s_ready, 1);

    // full 8-lane vector
    clr();
    for (int i = 1; i <= 8; i++) put(i, 1, i == 8);
    idle(12);
    chk("full_npv", pv_c.size(), 1);
    chk("full_pvcyc", (pv_c.size() > 0) ? pv_c[0] : -1, last_c + 1);
    chk("full_nov", ov_c.size(), 1);
    chk("full_ovcyc", (ov_c.size() > 0) ? ov_c[0] : -1, last_c + 2 + L);
    chk("full_sum", out_data, 36);
    chk("full_pe_a", (pv_a.size() > 0) ? pv_a[0] : '1, lanes(1, 1, 8));
    chk("full_pe_b", (pv_b.size() > 0) ? pv_b[0] : '1, lanes(1, 0, 8));
    chk("full_hold", pe_a, lanes(1, 1, 8));

    // partial 3-lane vector
    clr();
    put(2, 5, 0); put(3, 5, 0); put(4, 5, 1);
    idle(12);
    chk("part_pe_a", pe_a, lanes(2, 1, 3));
    chk("part_pe_b", pe_b, lanes(5, 0, 3));
    chk("part_nov", ov_c.size(), 1);
    chk("part_sum", out_data, 45);

    // 12 elements across two chunks
    clr();
    for (int k = 1; k <= 12; k++) put(1, k, k == 12);
    idle(12);
    chk("multi_npv", pv_c.size(), 2);
    chk("multi_nov", ov_c.size(), 1);
    chk("multi_sum", out_data, 78);
    chk("multi_pe_b", pe_b, lanes(9, 1, 4));

    // back-to-back products, last on lane 7
    clr();
    rdy_lo = 0;
    for (int i = 0; i < 8; i++) put(1, 1, i == 7);
    for (int i = 0; i < 8; i++) put(2, 3, i == 7);
    for (int i = 0; i < 8; i++) put(-3, 7, i == 7);
    idle(12);
    chk("b2b_ready", rdy_lo, 0);
    chk("b2b_npv", pv_c.size(), 3);
    chk("b2b_nov", ov_c.size(), 3);
    oc0 = (ov_c.size() > 0) ? ov_c[0] : 0;
    oc1 = (ov_c.size() > 1) ? ov_c[1] : 0;
    oc2 = (ov_c.size() > 2) ? ov_c[2] : 0;
    chk("b2b_gap1", oc1 - oc0, 8);
    chk("b2b_gap2", oc2 - oc1, 8);
    chk("b2b_s0", (ov_d.size() > 0) ? ov_d[0] : 32'hDEAD, 8);
    chk("b2b_s1", (ov_d.size() > 1) ? ov_d[1] : 32'hDEAD, 48);
    chk("b2b_neg", (ov_d.size() > 2) ? ov_d[2] : 32'hDEAD, 32'hFFFF_FF58);

    // flush mid-fill, flushed element carries s_last
    clr();
    for (int i = 0; i < 5; i++) put(9, 9, 0);
    s_if.s_valid = 1'b1;
    s_if.s_a     = 100;
    s_if.s_b     = 100;
    s_if.s_last  = 1'b1;
    flush        = 1'b1;
    #1;
    chk("flush_ready", s_if.s_ready, 0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) put(1, 1, i == 7);
    idle(12);
    chk("flush_npv", pv_c.size(), 1);
    chk("flush_nov", ov_c.size(), 1);
    chk("flush_sum", out_data, 8);
    chk("flush_lanes", pe_a, lanes(1, 0, 8));

    // flush clears a partially accumulated product
    clr();
    for (int i = 0; i < 8; i++) put(5, 1, 0);
    idle(10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    put(3, 4, 1);
    idle(12);
    chk("acc_flush_nov", ov_c.size(), 1);
    chk("acc_flush_sum", out_data, 12);

    // reset with two vectors in flight
    put(6, 1, 1);
    put(7, 1, 1);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_pe_vld", pe_vld, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_pe_a", pe_a, 0);
    chk("mrst_out_vld", out_vld, 0);
`ifdef DTC_FEEDER_PERF_EN
    chk("perf_iss_rst", perf_issue_cnt, 0);
    chk("perf_res_rst", perf_result_cnt, 0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    clr();
    idle(12);
    chk("mrst_npv", pv_c.size(), 0);
    chk("mrst_nov", ov_c.size(), 0);

`ifdef DTC_FEEDER_PERF_EN
    put(2, 2, 1);
    idle(10);
    chk("perf_iss", perf_issue_cnt, 1);
    chk("perf_res", perf_result_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
